// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with any depth >= 2 (non-power-of-two allowed),
// runtime-programmable almost-full / almost-empty thresholds, a registered read
// data path with read-valid strobe, and a live occupancy output.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   data_in, wr_en    write data / write request
//   rd_en             read request
//   afull_thresh      almostfull asserts when level >= afull_thresh
//   aempty_thresh     almostempty asserts when level <= aempty_thresh
//   data_out          registered read data, held when no read is accepted
//   rd_valid          data_out was loaded by a read accepted last cycle
//   wr_ack            write accepted last cycle
//   overflow          write rejected (full) last cycle
//   underflow         read rejected (empty) last cycle
//   full, empty       occupancy flags (combinational from level)
//   almostfull/empty  threshold flags (combinational from level and thresholds)
//   level             current occupancy
//
// Optional build macro FIFO_PEAK_LEVEL_EN adds:
//   peak_clr          reload peak_level from the current level
//   peak_level        highest level seen since reset or the last peak_clr
module sync_fifo_prog #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      afull_thresh,
  input  logic [CNT_W-1:0]      aempty_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
`ifdef FIFO_PEAK_LEVEL_EN
  input  logic                  peak_clr,
  output logic [CNT_W-1:0]      peak_level,
`endif
  output logic [CNT_W-1:0]      level
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Status flags straight from the occupancy counter.
  assign full        = (level_q == DEPTH_CNT);
  assign empty       = (level_q == '0);
  assign almostfull  = (level_q >= afull_thresh);
  assign almostempty = (level_q <= aempty_thresh);

  // A read on a full FIFO frees the slot the concurrent write uses.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  // Next-state for pointers, level and registered outputs.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    data_out_d  = data_out_q;
    rd_valid_d  = rd_acc;
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && !wr_acc;
    underflow_d = rd_en && !rd_acc;

    if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_acc) begin
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      data_out_d = mem[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= data_in;
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign level     = level_q;

`ifdef FIFO_PEAK_LEVEL_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  // A clear concurrent with a fill loads the post-update level.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr)                peak_d = (level_d > level_q) ? level_d : level_q;
    else if (level_d > peak_q)   peak_d = level_d;
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a DEPTH=8 and a DEPTH=6 instance share one clock.
// Read data is checked by per-instance monitors against expectation queues;
// status outputs are checked after each directed step.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // DEPTH=8 instance signals
  logic        rst8, wr8, rd8;
  logic [15:0] din8, dout8;
  logic [3:0]  aft8, aet8, lvl8;
  logic        rv8, ack8, ov8, un8, full8, empty8, af8, ae8;
  // DEPTH=6 instance signals
  logic        rst6, wr6, rd6;
  logic [15:0] din6, dout6;
  logic [2:0]  aft6, aet6, lvl6;
  logic        rv6, ack6, ov6, un6, full6, empty6, af6, ae6;
`ifdef FIFO_PEAK_LEVEL_EN
  logic        pclr8, pclr6;
  logic [3:0]  pk8;
  logic [2:0]  pk6;
`endif

  logic [15:0] exp8[$];
  logic [15:0] exp6[$];

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u8 (
    .clk(clk), .rst(rst8), .data_in(din8), .wr_en(wr8), .rd_en(rd8),
    .afull_thresh(aft8), .aempty_thresh(aet8), .data_out(dout8),
    .rd_valid(rv8), .wr_ack(ack8), .overflow(ov8), .underflow(un8),
    .full(full8), .empty(empty8), .almostfull(af8), .almostempty(ae8),
`ifdef FIFO_PEAK_LEVEL_EN
    .peak_clr(pclr8), .peak_level(pk8),
`endif
    .level(lvl8));

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) u6 (
    .clk(clk), .rst(rst6), .data_in(din6), .wr_en(wr6), .rd_en(rd6),
    .afull_thresh(aft6), .aempty_thresh(aet6), .data_out(dout6),
    .rd_valid(rv6), .wr_ack(ack6), .overflow(ov6), .underflow(un6),
    .full(full6), .empty(empty6), .almostfull(af6), .almostempty(ae6),
`ifdef FIFO_PEAK_LEVEL_EN
    .peak_clr(pclr6), .peak_level(pk6),
`endif
    .level(lvl6));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-data monitors: pop an expectation whenever rd_valid is seen.
  initial forever begin
    tick();
    if (rv8) begin
      if (exp8.size() == 0) chk("u8.unexpected_rd_valid", 32'(dout8), 32'hFFFF_FFFF);
      else chk("u8.rd_data", 32'(dout8), 32'(exp8.pop_front()));
    end
  end

  initial forever begin
    tick();
    if (rv6) begin
      if (exp6.size() == 0) chk("u6.unexpected_rd_valid", 32'(dout6), 32'hFFFF_FFFF);
      else chk("u6.rd_data", 32'(dout6), 32'(exp6.pop_front()));
    end
  end

  task automatic op8(input bit w, input bit r, input logic [15:0] d);
    wr8 = w; rd8 = r; din8 = d;
    tick();
    wr8 = 1'b0; rd8 = 1'b0;
  endtask

  task automatic op6(input bit w, input bit r, input logic [15:0] d);
    wr6 = w; rd6 = r; din6 = d;
    tick();
    wr6 = 1'b0; rd6 = 1'b0;
  endtask

  task automatic st8(input string t, input int lv, input bit ack, input bit ov,
                     input bit un, input bit rv);
    chk({t, ".level"},     32'(lvl8),   32'(lv));
    chk({t, ".wr_ack"},    32'(ack8),   32'(ack));
    chk({t, ".overflow"},  32'(ov8),    32'(ov));
    chk({t, ".underflow"}, 32'(un8),    32'(un));
    chk({t, ".rd_valid"},  32'(rv8),    32'(rv));
    chk({t, ".full"},      32'(full8),  32'(lv == 8));
    chk({t, ".empty"},     32'(empty8), 32'(lv == 0));
    chk({t, ".afull"},     32'(af8),    32'(lv >= int'(aft8)));
    chk({t, ".aempty"},    32'(ae8),    32'(lv <= int'(aet8)));
  endtask

  task automatic st6(input string t, input int lv, input bit ack, input bit rv);
    chk({t, ".level"},    32'(lvl6),   32'(lv));
    chk({t, ".wr_ack"},   32'(ack6),   32'(ack));
    chk({t, ".rd_valid"}, 32'(rv6),    32'(rv));
    chk({t, ".full"},     32'(full6),  32'(lv == 6));
    chk({t, ".empty"},    32'(empty6), 32'(lv == 0));
    chk({t, ".aempty"},   32'(ae6),    32'(lv <= 2));
  endtask

  initial begin
    rst8 = 1'b1; wr8 = 1'b0; rd8 = 1'b0; din8 = '0; aft8 = 4'd6; aet8 = 4'd2;
    rst6 = 1'b1; wr6 = 1'b0; rd6 = 1'b0; din6 = '0; aft6 = 3'd6; aet6 = 3'd2;
`ifdef FIFO_PEAK_LEVEL_EN
    pclr8 = 1'b0; pclr6 = 1'b0;
`endif
    repeat (2) tick();
    rst8 = 1'b0; rst6 = 1'b0;
    st8("reset", 0, 0, 0, 0, 0);
    chk("reset.data_out", 32'(dout8), 32'h0);
    st6("u6.reset", 0, 0, 0);

    // Fill 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      exp8.push_back(16'(i));
      op8(1, 0, 16'(i));
      st8("fill", i, 1, 0, 0, 0);
    end

    // Writes while full are rejected each cycle
    for (int i = 0; i < 3; i++) begin
      op8(1, 0, 16'hDEAD);
      st8("ovf", 8, 0, 1, 0, 0);
    end

    // Threshold extremes, flags follow combinationally
    aft8 = 4'd0; #1 chk("thr.afull_zero", 32'(af8), 32'h1);
    aft8 = 4'd9; #1 chk("thr.afull_above_depth", 32'(af8), 32'h0);
    aet8 = 4'd8; #1 chk("thr.aempty_depth", 32'(ae8), 32'h1);
    aft8 = 4'd6; aet8 = 4'd2; #1;

    for (int i = 1; i <= 8; i++) begin
      op8(0, 1, '0);
      st8("drain", 8 - i, 0, 0, 0, 1);
    end

    // Empty with simultaneous write/read: write wins, read underflows, no bypass
    exp8.push_back(16'hBEEF);
    op8(1, 1, 16'hBEEF);
    st8("empty_rw", 1, 1, 0, 1, 0);
    op8(0, 1, '0);
    st8("read_beef", 0, 0, 0, 0, 1);
    op8(0, 1, '0);
    st8("underflow", 0, 0, 0, 1, 0);
    chk("underflow.data_hold", 32'(dout8), 32'hBEEF);

    // Full with simultaneous read/write
    for (int i = 0; i < 8; i++) begin
      exp8.push_back(16'(16'h10 + i));
      op8(1, 0, 16'(16'h10 + i));
      st8("refill", i + 1, 1, 0, 0, 0);
    end
    exp8.push_back(16'h00AA);
    op8(1, 1, 16'h00AA);
    st8("full_rw", 8, 1, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      op8(0, 1, '0);
      st8("drain2", 8 - i, 0, 0, 0, 1);
    end

    // Mid-operation reset discards stored data
    for (int i = 0; i < 5; i++) op8(1, 0, 16'(16'h30 + i));
    chk("pre_rst.level", 32'(lvl8), 32'd5);
    rst8 = 1'b1; wr8 = 1'b1; din8 = 16'h0055;
    tick();
    rst8 = 1'b0; wr8 = 1'b0;
    exp8.delete();
    st8("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst.data_out", 32'(dout8), 32'h0);
`ifdef FIFO_PEAK_LEVEL_EN
    chk("mid_rst.peak", 32'(pk8), 32'h0);
`endif
    for (int i = 0; i < 3; i++) begin
      exp8.push_back(16'(16'h40 + i));
      op8(1, 0, 16'(16'h40 + i));
    end
    st8("fill3", 3, 1, 0, 0, 0);
`ifdef FIFO_PEAK_LEVEL_EN
    chk("fill3.peak", 32'(pk8), 32'd3);
    pclr8 = 1'b1; op8(0, 0, '0); pclr8 = 1'b0;
    chk("clr.peak", 32'(pk8), 32'd3);
`endif
    op8(0, 1, '0);
    op8(0, 1, '0);
    st8("read2", 1, 0, 0, 0, 1);
`ifdef FIFO_PEAK_LEVEL_EN
    chk("read2.peak", 32'(pk8), 32'd3);
    exp8.push_back(16'h0050);
    pclr8 = 1'b1; op8(1, 0, 16'h0050); pclr8 = 1'b0;
    chk("clr_wr.peak", 32'(pk8), 32'd2);
    op8(0, 1, '0);
`endif
    op8(0, 1, '0);
    st8("final8", 0, 0, 0, 0, 1);

    // DEPTH=6: pointer wrap 5 -> 0 on both sides
    for (int i = 0; i < 6; i++) begin
      exp6.push_back(16'(16'hA0 + i));
      op6(1, 0, 16'(16'hA0 + i));
      st6("u6.fill", i + 1, 1, 0);
    end
    for (int i = 0; i < 3; i++) begin
      op6(0, 1, '0);
      st6("u6.read3", 5 - i, 0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      exp6.push_back(16'(16'hB0 + i));
      op6(1, 0, 16'(16'hB0 + i));
      st6("u6.wrap_wr", 4 + i, 1, 0);
    end
    for (int i = 0; i < 6; i++) begin
      op6(0, 1, '0);
      st6("u6.drain", 5 - i, 0, 1);
    end

    tick(); tick();
    chk("u8.queue_drained", 32'(exp8.size()), 32'd0);
    chk("u6.queue_drained", 32'(exp6.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
